// File: rtl/player_input_ctrl_if.sv
// Switch-level inputs and game-event outputs of the player input controller.
// The controller takes the slave view; whatever drives the switches takes the master view.
interface player_input_ctrl_if;
  logic       i_Left;
  logic       i_Right;
  logic       i_Fire;
  logic       i_Fire_Ack;
  logic       o_Move_Left;
  logic       o_Move_Right;
  logic       o_Fire_Req;
  logic       o_Fire_Busy;
  logic [7:0] o_Shot_Count;

  modport slave (
    input  i_Left, i_Right, i_Fire, i_Fire_Ack,
    output o_Move_Left, o_Move_Right, o_Fire_Req, o_Fire_Busy, o_Shot_Count
  );

  modport master (
    output i_Left, i_Right, i_Fire, i_Fire_Ack,
    input  o_Move_Left, o_Move_Right, o_Fire_Req, o_Fire_Busy, o_Shot_Count
  );
endinterface

// File: rtl/player_input_ctrl.sv
// Turns debounced Left/Right/Fire levels into move pulses with hold-to-repeat
// and a cooldown-limited fire request using a req/ack handshake.
module player_input_ctrl #(
  parameter int unsigned HOLD_DELAY    = 12_500_000,
  parameter int unsigned REPEAT_PERIOD = 2_500_000,
  parameter int unsigned FIRE_COOLDOWN = 6_250_000
) (
  input  logic                i_Clk,
  input  logic                i_Rst,
  player_input_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {M_IDLE, M_HOLD, M_REPEAT} move_state_e;
  typedef enum logic [1:0] {F_IDLE, F_REQ, F_COOL} fire_state_e;

  localparam logic [23:0] HoldLast   = 24'(HOLD_DELAY - 1);
  localparam logic [23:0] RepeatLast = 24'(REPEAT_PERIOD - 1);
  localparam logic [23:0] CoolLast   = 24'(FIRE_COOLDOWN - 1);

  logic r_Left_q, r_Right_q, r_Fire_q;

  // Previous levels reset to 1 so a button held through reset needs a fresh press.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_Left_q  <= 1'b1;
      r_Right_q <= 1'b1;
      r_Fire_q  <= 1'b1;
    end else begin
      r_Left_q  <= bus.i_Left;
      r_Right_q <= bus.i_Right;
      r_Fire_q  <= bus.i_Fire;
    end
  end

  logic       conflict;
  logic [1:0] level;
  logic [1:0] prevLevel;

  assign conflict  = bus.i_Left & bus.i_Right;
  assign level     = {bus.i_Right, bus.i_Left};
  assign prevLevel = {r_Right_q, r_Left_q};

  // Index 0 is left, index 1 is right.
  for (genvar d = 0; d < 2; d++) begin : g_dir
    move_state_e state_q, state_d;
    logic [23:0] cnt_q, cnt_d;
    logic        pulse_q, pulse_d;

    always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
        state_q <= M_IDLE;
        cnt_q   <= '0;
        pulse_q <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        pulse_q <= pulse_d;
      end
    end

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pulse_d = 1'b0;
      if (conflict || !level[d]) begin
        state_d = M_IDLE;
        cnt_d   = '0;
      end else begin
        unique case (state_q)
          M_IDLE: begin
            if (!prevLevel[d]) begin
              pulse_d = 1'b1;
              cnt_d   = '0;
              state_d = M_HOLD;
            end
          end
          M_HOLD: begin
            if (cnt_q == HoldLast) begin
              pulse_d = 1'b1;
              cnt_d   = '0;
              state_d = M_REPEAT;
            end else begin
              cnt_d = cnt_q + 24'd1;
            end
          end
          M_REPEAT: begin
            if (cnt_q == RepeatLast) begin
              pulse_d = 1'b1;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 24'd1;
            end
          end
          default: begin
            state_d = M_IDLE;
            cnt_d   = '0;
          end
        endcase
      end
    end
  end

  assign bus.o_Move_Left  = g_dir[0].pulse_q;
  assign bus.o_Move_Right = g_dir[1].pulse_q;

  fire_state_e fireState_q, fireState_d;
  logic [23:0] fireCnt_q, fireCnt_d;
  logic [7:0]  shotCount_q, shotCount_d;

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      fireState_q <= F_IDLE;
      fireCnt_q   <= '0;
      shotCount_q <= '0;
    end else begin
      fireState_q <= fireState_d;
      fireCnt_q   <= fireCnt_d;
      shotCount_q <= shotCount_d;
    end
  end

  // Rises outside F_IDLE are dropped, so holding Fire never auto-fires.
  always_comb begin
    fireState_d = fireState_q;
    fireCnt_d   = fireCnt_q;
    shotCount_d = shotCount_q;
    unique case (fireState_q)
      F_IDLE: begin
        if (bus.i_Fire && !r_Fire_q) fireState_d = F_REQ;
      end
      F_REQ: begin
        if (bus.i_Fire_Ack) begin
          fireState_d = F_COOL;
          fireCnt_d   = '0;
          shotCount_d = shotCount_q + 8'd1;
        end
      end
      F_COOL: begin
        if (fireCnt_q == CoolLast) begin
          fireState_d = F_IDLE;
          fireCnt_d   = '0;
        end else begin
          fireCnt_d = fireCnt_q + 24'd1;
        end
      end
      default: begin
        fireState_d = F_IDLE;
        fireCnt_d   = '0;
      end
    endcase
  end

  assign bus.o_Fire_Req   = (fireState_q == F_REQ);
  assign bus.o_Fire_Busy  = (fireState_q != F_IDLE);
  assign bus.o_Shot_Count = shotCount_q;

endmodule

// File: tb/tb_player_input_ctrl.sv
// Scoreboard bench: a timeline-based reference model queues the expected outputs
// for every clock edge and an independent monitor compares the DUT against them.
module tb_player_input_ctrl;
  localparam int HD = 8;
  localparam int RP = 4;
  localparam int FC = 6;

  typedef struct {
    int         cyc;
    logic       ml;
    logic       mr;
    logic       req;
    logic       busy;
    logic [7:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  player_input_ctrl_if io();

  player_input_ctrl #(
    .HOLD_DELAY   (HD),
    .REPEAT_PERIOD(RP),
    .FIRE_COOLDOWN(FC)
  ) dut (
    .i_Clk(clk),
    .i_Rst(rst),
    .bus  (io)
  );

  exp_t sbQ[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state: moves are timed from the press edge, fire from the ack edge.
  int cyc = 0;
  bit prevLv[2];
  bit prevF;
  int start[2];
  bit pending;
  int coolEnd;
  int shots;

  function automatic bit stepDir(input int d, input bit lvl, input bit conflict);
    int e;
    bit pulse;
    pulse = 1'b0;
    if (conflict || !lvl) begin
      start[d] = -1;
    end else if (!prevLv[d]) begin
      start[d] = cyc;
      pulse    = 1'b1;
    end else if (start[d] >= 0) begin
      e     = cyc - start[d];
      pulse = (e == HD) || (e > HD && ((e - HD) % RP) == 0);
    end
    return pulse;
  endfunction

  task automatic applyStimulus(input bit r, input bit l, input bit rt, input bit f, input bit ack);
    exp_t e;
    @(negedge clk);
    rst           = r;
    io.i_Left     = l;
    io.i_Right    = rt;
    io.i_Fire     = f;
    io.i_Fire_Ack = ack;
    cyc++;
    if (r) begin
      prevLv[0] = 1'b1;
      prevLv[1] = 1'b1;
      prevF     = 1'b1;
      start[0]  = -1;
      start[1]  = -1;
      pending   = 1'b0;
      coolEnd   = cyc;
      shots     = 0;
      e.ml      = 1'b0;
      e.mr      = 1'b0;
    end else begin
      e.ml = stepDir(0, l, l && rt);
      e.mr = stepDir(1, rt, l && rt);
      prevLv[0] = l;
      prevLv[1] = rt;
      if (pending && ack) begin
        pending = 1'b0;
        shots   = (shots + 1) % 256;
        coolEnd = cyc + FC;
      end else if (!pending && cyc > coolEnd && f && !prevF) begin
        pending = 1'b1;
      end
      prevF = f;
    end
    e.cyc  = cyc;
    e.req  = pending;
    e.busy = pending || (cyc < coolEnd);
    e.cnt  = 8'(shots);
    sbQ.push_back(e);
  endtask

  task automatic checkOutput(input string name, input int cycN, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s cycle=%0d got=%0h expected=%0h", name, cycN, got, exp);
    end
  endtask

  // Monitor: outputs are presented after every edge, so compare just after it.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sbQ.size() > 0) begin
        e = sbQ.pop_front();
        checkOutput("moveLeft",  e.cyc, {7'd0, io.o_Move_Left},  {7'd0, e.ml});
        checkOutput("moveRight", e.cyc, {7'd0, io.o_Move_Right}, {7'd0, e.mr});
        checkOutput("fireReq",   e.cyc, {7'd0, io.o_Fire_Req},   {7'd0, e.req});
        checkOutput("fireBusy",  e.cyc, {7'd0, io.o_Fire_Busy},  {7'd0, e.busy});
        checkOutput("shotCount", e.cyc, io.o_Shot_Count,         e.cnt);
      end
    end
  end

  initial begin
    bit l, r, f;
    io.i_Left     = 1'b0;
    io.i_Right    = 1'b0;
    io.i_Fire     = 1'b0;
    io.i_Fire_Ack = 1'b0;

    repeat (3) applyStimulus(1, 0, 0, 0, 0);

    // Left held 30 cycles: pulses at 0, 8, 12, ... 28.
    repeat (30) applyStimulus(0, 1, 0, 0, 0);
    repeat (5)  applyStimulus(0, 0, 0, 0, 0);

    // Right pressed while Left held, then Left must be re-pressed.
    repeat (3)  applyStimulus(0, 1, 0, 0, 0);
    repeat (7)  applyStimulus(0, 1, 1, 0, 0);
    repeat (5)  applyStimulus(0, 1, 0, 0, 0);
    repeat (2)  applyStimulus(0, 0, 0, 0, 0);
    repeat (10) applyStimulus(0, 1, 0, 0, 0);
    repeat (3)  applyStimulus(0, 0, 0, 0, 0);

    // Fire rise at k, ack at k+3, discarded rise at k+5.
    applyStimulus(0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 0);
    repeat (10) applyStimulus(0, 0, 0, 0, 0);

    // Ack on the rise edge is ignored; Fire held through cooldown fires once.
    applyStimulus(0, 0, 0, 1, 1);
    applyStimulus(0, 0, 0, 1, 1);
    repeat (12) applyStimulus(0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 1, 1);
    repeat (10) applyStimulus(0, 0, 0, 0, 0);

    // 256 handshakes wrap the count; stray acks must not count.
    applyStimulus(1, 0, 0, 0, 0);
    for (int i = 0; i < 256; i++) begin
      applyStimulus(0, 0, 0, 1, 0);
      applyStimulus(0, 0, 0, 0, 1);
      repeat (FC) applyStimulus(0, 0, 0, 0, 1'($urandom_range(0, 1)));
      applyStimulus(0, 0, 0, 0, 1);
    end
    repeat (3) applyStimulus(0, 0, 0, 0, 0);

    // Reset mid-repeat and mid-request with Left and Fire held.
    repeat (14) applyStimulus(0, 1, 0, 1, 0);
    repeat (2)  applyStimulus(1, 1, 0, 1, 0);
    repeat (10) applyStimulus(0, 1, 0, 1, 0);
    repeat (2)  applyStimulus(0, 0, 0, 0, 0);
    repeat (3)  applyStimulus(0, 1, 0, 1, 0);
    applyStimulus(0, 1, 0, 1, 1);
    repeat (8)  applyStimulus(0, 0, 0, 0, 0);

    // Randomized levels, acks and occasional resets.
    l = 1'b0; r = 1'b0; f = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) l = ~l;
      if ($urandom_range(0, 7) == 0) r = ~r;
      if ($urandom_range(0, 4) == 0) f = ~f;
      applyStimulus(1'($urandom_range(0, 299) == 0), l, r, f, 1'($urandom_range(0, 2) == 0));
    end
    applyStimulus(0, 0, 0, 0, 0);

    for (int i = 0; i < 10 && sbQ.size() > 0; i++) @(posedge clk);
    #2;
    if (sbQ.size() > 0) begin
      errors++;
      $display("[TB] FAIL drain pending=%0d expected=0", sbQ.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/player_input_ctrl.md
# player_input_ctrl

Converts the debounced Left, Right and Fire switch levels of the Meteorite Shooter into game events. It sits directly downstream of the three switch debouncers and upstream of the ship-position and projectile logic. It generates one-cycle move pulses with hold-to-auto-repeat, and a rate-limited fire request with a req/ack handshake.

## Interface
- HOLD_DELAY, 12_500_000, cycles from initial press pulse to first auto-repeat pulse (500 ms at 25 MHz); legal range 2..2^24-1
- REPEAT_PERIOD, 2_500_000, cycles between successive auto-repeat pulses (100 ms); legal range 1..2^24-1
- FIRE_COOLDOWN, 6_250_000, cycles from fire acknowledge to next shot allowed (250 ms); legal range 1..2^24-1
- i_Clk  in  1  system clock, 25 MHz; all logic on rising edge
- i_Rst  in  1  synchronous, active-high reset
- i_Left  in  1  debounced left switch level, 1 = pressed
- i_Right  in  1  debounced right switch level, 1 = pressed
- i_Fire  in  1  debounced fire switch level, 1 = pressed
- i_Fire_Ack  in  1  projectile logic accepts the pending shot
- o_Move_Left  out  1  one-cycle move-left pulse
- o_Move_Right  out  1  one-cycle move-right pulse
- o_Fire_Req  out  1  shot request, held until acknowledged
- o_Fire_Busy  out  1  high whenever the fire FSM is not in F_IDLE
- o_Shot_Count  out  8  number of acknowledged shots, wraps modulo 256

## Operation
- Edge detection: the previous-level registers r_Left_q, r_Right_q and r_Fire_q sample their inputs every cycle. A rise is input = 1 while the previous level = 0.
- Direction FSM, one instance per direction, states M_IDLE, M_HOLD, M_REPEAT:
  - M_IDLE: on a rise, pulse the output, clear the counter, go to M_HOLD.
  - M_HOLD: while the input stays high, count. At count HOLD_DELAY-1, pulse, clear the counter, go to M_REPEAT.
  - M_REPEAT: count. At count REPEAT_PERIOD-1, pulse and clear the counter.
  - Input low in any state: go to M_IDLE, clear the counter, no pulse.
- Conflict: while i_Left and i_Right are both 1, both FSMs are forced to M_IDLE and no move pulses are produced. The previous-level registers keep tracking, so the button still held after the other is released does not move until it is released and pressed again.
- Fire FSM, states F_IDLE, F_REQ, F_COOL:
  - F_IDLE: a rise of i_Fire causes o_Fire_Req = 1 and a move to F_REQ.
  - F_REQ: hold o_Fire_Req. When i_Fire_Ack = 1 is sampled, drop the request, increment o_Shot_Count, clear the counter, go to F_COOL.
  - F_COOL: count. At count FIRE_COOLDOWN-1, go to F_IDLE.
  - Fire rises while in F_REQ or F_COOL are discarded, not queued. A button still held at the end of cooldown does not fire; a fresh rise is required (no auto-fire).
  - i_Fire_Ack outside F_REQ is ignored.
  - o_Fire_Busy = (state != F_IDLE).
- Counters are 24-bit unsigned and are never allowed to exceed their terminal value.
- o_Shot_Count: 8-bit unsigned, increments by 1 per handshake, 255 wraps to 0.

## Timing
- All outputs are registered.
- Reset values:
  - o_Move_Left, o_Move_Right, o_Fire_Req, o_Fire_Busy: 0
  - o_Shot_Count: 0
  - all FSMs in IDLE state, all counters 0
- Reset loads r_Left_q, r_Right_q and r_Fire_q to 1. A button held through reset therefore produces no event until it is released and pressed again.
- Reset mid-operation (any state, including a pending request) aborts immediately. Any pending shot is lost and the count returns to 0.
- Press latency: if the input is first seen high at edge k, the output pulse is high for the cycle following edge k, exactly one cycle wide.
- Auto-repeat: held from edge k, pulses occur at edges k, k+HOLD_DELAY, then k+HOLD_DELAY+n*REPEAT_PERIOD for n = 1, 2, ...
- Fire timing:
  - Rise at edge k: o_Fire_Req is high after edge k.
  - Ack sampled at edge m: o_Fire_Req is low and o_Shot_Count is updated after edge m.
  - o_Fire_Busy falls after edge m+FIRE_COOLDOWN.
  - Ack sampled in the same cycle the request rises (edge k) is ignored; the earliest accepted ack is at edge k+1.
- Release in the same cycle a repeat pulse is due: release wins, no pulse.
- Move and fire paths are independent; simultaneous events on both are all honoured.

## Test plan
- Test parameters for all scenarios: HOLD_DELAY = 8, REPEAT_PERIOD = 4, FIRE_COOLDOWN = 6.
- Left held 30 cycles from edge k, then released -> o_Move_Left pulses at k, k+8, k+12, k+16, k+20, k+24, k+28 only; o_Move_Right stays 0.
- Left held, then Right pressed at k+3 and released at k+10 with Left still held -> no pulses from k+3 onward. Left released and re-pressed at edge j -> a pulse at j.
- Fire rise at edge k, ack at k+3 -> o_Fire_Req high for k..k+2 and low after k+3; o_Shot_Count = 1; o_Fire_Busy low after k+9. A second fire rise at k+5 produces no request.
- Fire held continuously through cooldown -> exactly one shot. After release and re-press -> a second request; count = 2.
- 256 complete fire handshakes -> o_Shot_Count reads 0 afterwards; ack pulses with no request pending do not change the count.
- i_Left and i_Fire held while i_Rst pulses high mid-repeat and mid-request -> all outputs 0 after reset, no events while both remain held, and normal events resume after release and re-press.
